// File: rtl/imm_gen_pipe.sv
// LEGv8 immediate generator: combinational decode of D/CB/B/I/IW formats
// feeding a PIPE_STAGES-deep valid/ready register chain with flush and error count.
module imm_gen_pipe #(
    parameter int XLEN         = 64,
    parameter int PIPE_STAGES  = 1,
    parameter int SHIFT_BRANCH = 0,
    parameter int TAG_W        = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm,
    output logic [2:0]       fmt,
    output logic [TAG_W-1:0] out_tag,
    output logic [15:0]      err_cnt
);

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_D    = 3'd1;
    localparam logic [2:0] FMT_CB   = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_I    = 3'd4;
    localparam logic [2:0] FMT_IW   = 3'd5;

    logic [XLEN-1:0] imm_d;
    logic [2:0]      fmt_d;

    always_comb begin
        imm_d = '0;
        fmt_d = FMT_NONE;
        if (instr[31:21] == 11'b11111000010 || instr[31:21] == 11'b11111000000) begin
            fmt_d = FMT_D;
            imm_d = {{(XLEN-9){instr[20]}}, instr[20:12]};
        end else if (instr[31:25] == 7'b1011010) begin
            fmt_d = FMT_CB;
            imm_d = {{(XLEN-19){instr[23]}}, instr[23:5]};
            if (SHIFT_BRANCH != 0) imm_d = {imm_d[XLEN-3:0], 2'b00};
        end else if (instr[31:26] == 6'b000101) begin
            fmt_d = FMT_B;
            imm_d = {{(XLEN-26){instr[25]}}, instr[25:0]};
            if (SHIFT_BRANCH != 0) imm_d = {imm_d[XLEN-3:0], 2'b00};
        end else if (instr[31:22] == 10'b1001000100 || instr[31:22] == 10'b1101000100) begin
            fmt_d = FMT_I;
            imm_d = {{(XLEN-12){1'b0}}, instr[21:10]};
        end else if (instr[31:23] == 9'b110100101) begin
            // A 32-bit immediate cannot hold the upper two MOVZ half-words.
            if (!(XLEN == 32 && instr[22])) begin
                fmt_d = FMT_IW;
                imm_d = {{(XLEN-16){1'b0}}, instr[20:5]} << {instr[22:21], 4'b0000};
            end
        end
    end

    // Valid/ready: a transfer happens on a rising edge where valid && ready;
    // the producer holds its data stable while valid && !ready.
    logic [PIPE_STAGES-1:0] v;
    logic [PIPE_STAGES-1:0] adv;
    logic [PIPE_STAGES-1:0] src_v;
    logic [XLEN-1:0]        imm_r   [PIPE_STAGES];
    logic [2:0]             fmt_r   [PIPE_STAGES];
    logic [TAG_W-1:0]       tag_r   [PIPE_STAGES];
    logic [XLEN-1:0]        src_imm [PIPE_STAGES];
    logic [2:0]             src_fmt [PIPE_STAGES];
    logic [TAG_W-1:0]       src_tag [PIPE_STAGES];

    // A stage advances if any stage at or after it is empty, or the consumer takes.
    always_comb begin
        for (int i = 0; i < PIPE_STAGES; i++) begin
            adv[i] = out_ready;
            for (int j = i; j < PIPE_STAGES; j++) begin
                if (!v[j]) adv[i] = 1'b1;
            end
        end
    end

    assign in_ready = adv[0] && !flush;

    always_comb begin
        src_v[0]   = in_valid && in_ready;
        src_imm[0] = imm_d;
        src_fmt[0] = fmt_d;
        src_tag[0] = in_tag;
        for (int i = 1; i < PIPE_STAGES; i++) begin
            src_v[i]   = v[i-1];
            src_imm[i] = imm_r[i-1];
            src_fmt[i] = fmt_r[i-1];
            src_tag[i] = tag_r[i-1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v <= '0;
            for (int i = 0; i < PIPE_STAGES; i++) begin
                imm_r[i] <= '0;
                fmt_r[i] <= '0;
                tag_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < PIPE_STAGES; i++) begin
                if (flush) begin
                    v[i] <= 1'b0;
                end else if (adv[i]) begin
                    v[i] <= src_v[i];
                end
                if (!flush && adv[i] && src_v[i]) begin
                    imm_r[i] <= src_imm[i];
                    fmt_r[i] <= src_fmt[i];
                    tag_r[i] <= src_tag[i];
                end
            end
        end
    end

    assign out_valid = v[PIPE_STAGES-1];
    assign imm       = imm_r[PIPE_STAGES-1];
    assign fmt       = fmt_r[PIPE_STAGES-1];
    assign out_tag   = tag_r[PIPE_STAGES-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_cnt <= '0;
        end else if (out_valid && out_ready && fmt == FMT_NONE && err_cnt != 16'hFFFF) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: a 3-stage 64-bit instance and a 1-stage 32-bit
// shifted-branch instance share stimulus; a scoreboard and decode model check both.
module tb_imm_gen_pipe;

    localparam int P = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        out_ready_b = 1'b1;
    logic [31:0] instr = '0;
    logic [7:0]  in_tag = '0;

    logic        in_ready_a, out_valid_a;
    logic [63:0] imm_a;
    logic [2:0]  fmt_a;
    logic [7:0]  out_tag_a;
    logic [15:0] err_cnt_a;

    logic        in_ready_b, out_valid_b;
    logic [31:0] imm_b;
    logic [2:0]  fmt_b;
    logic [7:0]  out_tag_b;
    logic [15:0] err_cnt_b;

    imm_gen_pipe #(.XLEN(64), .PIPE_STAGES(P), .SHIFT_BRANCH(0), .TAG_W(8)) dut_a (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_a), .instr(instr), .in_tag(in_tag),
        .out_valid(out_valid_a), .out_ready(out_ready), .imm(imm_a), .fmt(fmt_a),
        .out_tag(out_tag_a), .err_cnt(err_cnt_a)
    );

    imm_gen_pipe #(.XLEN(32), .PIPE_STAGES(1), .SHIFT_BRANCH(1), .TAG_W(8)) dut_b (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_b), .instr(instr), .in_tag(in_tag),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .imm(imm_b), .fmt(fmt_b),
        .out_tag(out_tag_b), .err_cnt(err_cnt_b)
    );

    // Clock / reset
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference decode from the format rules: returns {fmt, imm}, imm masked to xlen.
    function automatic logic [66:0] ref_decode(input logic [31:0] w, input int xlen, input bit shl);
        longint      val;
        int          f;
        int          hw;
        logic [63:0] u;
        f = 0;
        val = 0;
        if (w[31:21] == 11'h7C2 || w[31:21] == 11'h7C0) begin
            f = 1;
            val = w[20:12];
            if (val >= 256) val -= 512;
        end else if (w[31:24] == 8'hB4 || w[31:24] == 8'hB5) begin
            f = 2;
            val = w[23:5];
            if (val >= (longint'(1) << 18)) val -= (longint'(1) << 19);
            if (shl) val = val * 4;
        end else if (w[31:26] == 6'd5) begin
            f = 3;
            val = w[25:0];
            if (val >= (longint'(1) << 25)) val -= (longint'(1) << 26);
            if (shl) val = val * 4;
        end else if (w[31:22] == 10'h244 || w[31:22] == 10'h344) begin
            f = 4;
            val = w[21:10];
        end else if (w[31:23] == 9'h1A5) begin
            hw = int'(w[22:21]);
            if (!(xlen == 32 && hw >= 2)) begin
                f = 5;
                val = longint'(w[20:5]) * (longint'(1) << (16 * hw));
            end
        end
        u = val;
        if (xlen == 32) u[63:32] = '0;
        return {3'(f), u};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom();
        case ($urandom_range(0, 7))
            0: w[31:21] = ($urandom_range(0, 1) != 0) ? 11'b11111000010 : 11'b11111000000;
            1: w[31:24] = ($urandom_range(0, 1) != 0) ? 8'hB4 : 8'hB5;
            2: w[31:26] = 6'b000101;
            3: w[31:22] = ($urandom_range(0, 1) != 0) ? 10'b1001000100 : 10'b1101000100;
            4: w[31:23] = 9'b110100101;
            5: w = '0;
            default: ;
        endcase
        return w;
    endfunction

    // Scoreboard state
    logic [74:0] exp_q[$];
    logic [15:0] err_a = '0;
    logic [15:0] err_b = '0;
    logic [74:0] b_exp = '0;
    logic        b_exp_valid = 1'b0;
    logic        stall_prev = 1'b0;
    logic [63:0] prev_imm = '0;
    logic [2:0]  prev_fmt = '0;
    logic [7:0]  prev_tag = '0;
    logic        last_acc = 1'b0;
    logic        saw_ready_low = 1'b0;
    int          delivered = 0;

    // One cycle: inputs already set after a negedge; check, update model, advance.
    task automatic step();
        logic [74:0] e;
        #1;
        check("in_ready_a", 64'(in_ready_a), 64'(!flush && (exp_q.size() < P || out_ready)));
        check("in_ready_b", 64'(in_ready_b), 64'(!flush));
        check("err_cnt_a", 64'(err_cnt_a), 64'(err_a));
        check("err_cnt_b", 64'(err_cnt_b), 64'(err_b));
        check("out_valid_b", 64'(out_valid_b), 64'(b_exp_valid));
        if (b_exp_valid) begin
            check("tag_b", 64'(out_tag_b), 64'(b_exp[74:67]));
            check("fmt_b", 64'(fmt_b), 64'(b_exp[66:64]));
            check("imm_b", 64'(imm_b), b_exp[63:0]);
            if (b_exp[66:64] == 3'd0 && err_b != 16'hFFFF) err_b++;
        end
        if (stall_prev) begin
            check("hold_imm", imm_a, prev_imm);
            check("hold_fmt", 64'(fmt_a), 64'(prev_fmt));
            check("hold_tag", 64'(out_tag_a), 64'(prev_tag));
        end
        if (out_valid_a) begin
            if (exp_q.size() == 0) begin
                check("phantom_a", 64'(out_valid_a), 64'(0));
            end else begin
                e = exp_q[0];
                check("tag_a", 64'(out_tag_a), 64'(e[74:67]));
                check("fmt_a", 64'(fmt_a), 64'(e[66:64]));
                check("imm_a", imm_a, e[63:0]);
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    delivered++;
                    if (e[66:64] == 3'd0 && err_a != 16'hFFFF) err_a++;
                end
            end
        end
        last_acc = in_valid && in_ready_a;
        if (last_acc) exp_q.push_back({in_tag, ref_decode(instr, 64, 1'b0)});
        if (flush) exp_q.delete();
        if (!in_ready_a) saw_ready_low = 1'b1;
        stall_prev = out_valid_a && !out_ready && !flush;
        prev_imm = imm_a;
        prev_fmt = fmt_a;
        prev_tag = out_tag_a;
        b_exp_valid = in_valid && !flush;
        b_exp = {in_tag, ref_decode(instr, 32, 1'b1)};
        @(negedge clk);
    endtask

    task automatic clear_model();
        exp_q.delete();
        err_a = '0;
        err_b = '0;
        b_exp_valid = 1'b0;
        stall_prev = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid_a"}, 64'(out_valid_a), 64'(0));
        check({tag, "_imm_a"}, imm_a, 64'(0));
        check({tag, "_fmt_a"}, 64'(fmt_a), 64'(0));
        check({tag, "_tag_a"}, 64'(out_tag_a), 64'(0));
        check({tag, "_err_a"}, 64'(err_cnt_a), 64'(0));
        check({tag, "_valid_b"}, 64'(out_valid_b), 64'(0));
    endtask

    task automatic drain(input string tag);
        in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 12 && exp_q.size() != 0; k++) step();
        step();
        check(tag, 64'(exp_q.size()), 64'(0));
    endtask

    logic [31:0] d_instr [6] = '{32'hF85F5000, 32'hF800F000, 32'hB4FFFFE0,
                                 32'h16000000, 32'h913FFC00, 32'hD2C24680};
    logic [63:0] d_imm_a [6] = '{64'hFFFFFFFFFFFFFFF5, 64'h000000000000000F, 64'hFFFFFFFFFFFFFFFF,
                                 64'hFFFFFFFFFE000000, 64'h0000000000000FFF, 64'h0000123400000000};
    logic [2:0]  d_fmt_a [6] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
    logic [31:0] d_imm_b [6] = '{32'hFFFFFFF5, 32'h0000000F, 32'hFFFFFFFC,
                                 32'hF8000000, 32'h00000FFF, 32'h00000000};
    logic [2:0]  d_fmt_b [6] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};

    initial begin
        int sent;
        int cyc;
        int start_delivered;
        logic [7:0] tag_ctr;

        // Reset values while reset is held across an edge
        @(negedge clk);
        check_reset_outputs("rst");
        @(negedge clk);
        reset_n = 1'b1;

        // Directed decode, unstalled: B instance one cycle, A instance three cycles
        out_ready = 1'b1;
        for (int c = 0; c < 9; c++) begin
            in_valid = (c < 6);
            instr = (c < 6) ? d_instr[c] : 32'h0;
            in_tag = 8'(c);
            step();
            if (c < 6) begin
                check("dir_fmt_b", 64'(fmt_b), 64'(d_fmt_b[c]));
                check("dir_imm_b", 64'(imm_b), 64'(d_imm_b[c]));
            end
            if (c < 2) begin
                check("dir_lat_a", 64'(out_valid_a), 64'(0));
            end else if (c - 2 < 6) begin
                check("dir_valid_a", 64'(out_valid_a), 64'(1));
                check("dir_fmt_a", 64'(fmt_a), 64'(d_fmt_a[c-2]));
                check("dir_imm_a", imm_a, d_imm_a[c-2]);
            end
        end
        drain("dir_drain");

        // Backpressure: 10 tagged instructions, consumer stalls for 5 cycles
        sent = 0;
        cyc = 0;
        saw_ready_low = 1'b0;
        start_delivered = delivered;
        in_valid = 1'b1;
        instr = rand_instr();
        in_tag = 8'h40;
        while (sent < 10 && cyc < 40) begin
            out_ready = !(cyc >= 3 && cyc < 8);
            step();
            cyc++;
            if (last_acc) begin
                sent++;
                if (sent < 10) begin
                    instr = rand_instr();
                    in_tag = 8'(8'h40 + sent);
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        check("bp_sent", 64'(sent), 64'(10));
        check("bp_ready_drop", 64'(saw_ready_low), 64'(1));
        drain("bp_drain");
        check("bp_delivered", 64'(delivered - start_delivered), 64'(10));

        // Flush a full pipeline while an input is offered
        out_ready = 1'b0;
        in_valid = 1'b1;
        instr = rand_instr();
        in_tag = 8'h80;
        for (int k = 0; k < 4; k++) begin
            step();
            if (last_acc) begin
                instr = rand_instr();
                in_tag = in_tag + 8'd1;
            end
        end
        check("flush_full", 64'(exp_q.size()), 64'(P));
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_valid", 64'(out_valid_a), 64'(0));
        instr = 32'h913FFC00;
        in_tag = 8'hA5;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("flush_lat1", 64'(out_valid_a), 64'(0));
        step();
        check("flush_lat2", 64'(out_valid_a), 64'(0));
        step();
        check("flush_lat3", 64'(out_valid_a), 64'(1));
        check("flush_tag", 64'(out_tag_a), 64'(8'hA5));
        check("flush_imm", imm_a, 64'hFFF);
        drain("flush_drain");

        // Randomised traffic with random backpressure and occasional flush
        tag_ctr = 8'h00;
        for (int c = 0; c < 400; c++) begin
            if (!in_valid || last_acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                instr = rand_instr();
                in_tag = tag_ctr;
                tag_ctr = tag_ctr + 8'd1;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 49) == 0);
            step();
        end
        drain("rand_drain");
        check("err_seen", 64'(err_cnt_a != 16'd0), 64'(1));

        // Asynchronous reset mid-stream with a stalled, full pipeline
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            instr = rand_instr();
            in_tag = 8'(8'hC0 + k);
            step();
        end
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("arst");
        in_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        clear_model();

        // Three undecodable words delivered after reset
        out_ready = 1'b1;
        in_valid = 1'b1;
        instr = 32'h0;
        for (int k = 0; k < 3; k++) begin
            in_tag = 8'(8'hE0 + k);
            step();
        end
        drain("err_drain");
        check("err_three", 64'(err_cnt_a), 64'(3));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
